// File: rtl/tri_scan_rasterizer.sv
// Flat-shaded triangle rasterizer: clipped bbox walk with incremental edge functions, one fragment per covered pixel.
// Accept-to-first-fragment 4 clocks; a one-deep pending slot lets the final fragment carry out_last.
module tri_scan_rasterizer #(
  parameter int COORD_W   = 12,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int ADDR_W    = 26,
  parameter int COLOR_W   = 24,
  parameter bit CULL_BACK = 1'b0
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_in_valid,
  output logic                      o_in_ready,
  input  logic signed [COORD_W-1:0] i_x1,
  input  logic signed [COORD_W-1:0] i_y1,
  input  logic signed [COORD_W-1:0] i_x2,
  input  logic signed [COORD_W-1:0] i_y2,
  input  logic signed [COORD_W-1:0] i_x3,
  input  logic signed [COORD_W-1:0] i_y3,
  input  logic [COLOR_W-1:0]        i_color1,
  input  logic [ADDR_W-1:0]         i_fb_base,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic [ADDR_W-1:0]         o_out_addr,
  output logic [COLOR_W-1:0]        o_out_color,
  output logic                      o_out_last,
  output logic                      o_tri_done
);
  localparam int EW = 2*COORD_W + 3;
  typedef logic signed [COORD_W-1:0] crd_t;
  typedef logic signed [EW-1:0]      edg_t;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_INIT, S_SCAN, S_DRAIN, S_DONE} state_t;
  localparam crd_t XMAX = crd_t'(SCREEN_W - 1);
  localparam crd_t YMAX = crd_t'(SCREEN_H - 1);

  function automatic edg_t sx(input crd_t v);
    return edg_t'(v);
  endfunction

  function automatic edg_t edge_fn(input crd_t xa, input crd_t ya, input crd_t xb,
                                   input crd_t yb, input crd_t x, input crd_t y);
    return (sx(xb) - sx(xa)) * (sx(y) - sx(ya)) - (sx(yb) - sx(ya)) * (sx(x) - sx(xa));
  endfunction

  function automatic crd_t min3(input crd_t a, input crd_t b, input crd_t c);
    crd_t m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic crd_t max3(input crd_t a, input crd_t b, input crd_t c);
    crd_t m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  state_t             r_state;
  crd_t               r_vx [3];
  crd_t               r_vy [3];
  logic [COLOR_W-1:0] r_color;
  logic [ADDR_W-1:0]  r_base;
  crd_t               r_minx, r_maxx, r_miny, r_maxy, r_x, r_y;
  logic               r_neg, r_zero, r_empty;
  edg_t               r_e [3];
  edg_t               r_row_e [3];
  edg_t               r_stx [3];
  edg_t               r_sty [3];
  logic [ADDR_W-1:0]  r_row_addr, r_p_addr, r_o_addr;
  logic               r_p_vld, r_o_vld, r_o_last, r_done, r_in_ready;
  logic [COLOR_W-1:0] r_o_color;

  crd_t w_lox, w_hix, w_loy, w_hiy, w_minx, w_maxx, w_miny, w_maxy;
  edg_t w_area;
  edg_t w_e0 [3];
  edg_t w_stx [3];
  edg_t w_sty [3];
  logic w_cov, w_o_free, w_skip, w_row_end, w_last_px;
  logic [ADDR_W-1:0] w_pix_addr;

  always_comb begin
    w_lox  = min3(r_vx[0], r_vx[1], r_vx[2]);
    w_hix  = max3(r_vx[0], r_vx[1], r_vx[2]);
    w_loy  = min3(r_vy[0], r_vy[1], r_vy[2]);
    w_hiy  = max3(r_vy[0], r_vy[1], r_vy[2]);
    w_minx = (w_lox < 0) ? '0 : w_lox;
    w_miny = (w_loy < 0) ? '0 : w_loy;
    w_maxx = (w_hix > XMAX) ? XMAX : w_hix;
    w_maxy = (w_hiy > YMAX) ? YMAX : w_hiy;
    w_area = edge_fn(r_vx[0], r_vy[0], r_vx[1], r_vy[1], r_vx[2], r_vy[2]);
    // Edge i runs from vertex i to vertex i+1; clockwise triangles are flipped so "inside" is always >= 0.
    for (int i = 0; i < 3; i++) begin
      w_stx[i] = sx(r_vy[i]) - sx(r_vy[(i+1)%3]);
      w_sty[i] = sx(r_vx[(i+1)%3]) - sx(r_vx[i]);
      w_e0[i]  = edge_fn(r_vx[i], r_vy[i], r_vx[(i+1)%3], r_vy[(i+1)%3], r_minx, r_miny);
      if (r_neg) begin
        w_stx[i] = -w_stx[i];
        w_sty[i] = -w_sty[i];
        w_e0[i]  = -w_e0[i];
      end
    end
    w_cov      = !r_e[0][EW-1] && !r_e[1][EW-1] && !r_e[2][EW-1];
    w_o_free   = !r_o_vld || i_out_ready;
    w_skip     = r_zero || r_empty || (r_neg && CULL_BACK);
    w_row_end  = (r_x == r_maxx);
    w_last_px  = w_row_end && (r_y == r_maxy);
    w_pix_addr = r_row_addr + ADDR_W'($unsigned(r_x));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b1;
      r_o_vld    <= 1'b0;
      r_o_last   <= 1'b0;
      r_o_addr   <= '0;
      r_o_color  <= '0;
      r_done     <= 1'b0;
      r_p_vld    <= 1'b0;
      r_p_addr   <= '0;
      r_color    <= '0;
      r_base     <= '0;
      r_minx     <= '0;
      r_maxx     <= '0;
      r_miny     <= '0;
      r_maxy     <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_neg      <= 1'b0;
      r_zero     <= 1'b0;
      r_empty    <= 1'b0;
      r_row_addr <= '0;
      for (int i = 0; i < 3; i++) begin
        r_vx[i]    <= '0;
        r_vy[i]    <= '0;
        r_e[i]     <= '0;
        r_row_e[i] <= '0;
        r_stx[i]   <= '0;
        r_sty[i]   <= '0;
      end
    end else begin
      if (r_o_vld && i_out_ready) begin
        r_o_vld  <= 1'b0;
        r_o_last <= 1'b0;
      end
      case (r_state)
        S_IDLE: if (i_in_valid) begin
          r_vx[0]    <= i_x1;
          r_vy[0]    <= i_y1;
          r_vx[1]    <= i_x2;
          r_vy[1]    <= i_y2;
          r_vx[2]    <= i_x3;
          r_vy[2]    <= i_y3;
          r_color    <= i_color1;
          r_base     <= i_fb_base;
          r_in_ready <= 1'b0;
          r_state    <= S_SETUP;
        end
        S_SETUP: begin
          r_minx  <= w_minx;
          r_maxx  <= w_maxx;
          r_miny  <= w_miny;
          r_maxy  <= w_maxy;
          r_neg   <= w_area[EW-1];
          r_zero  <= (w_area == '0);
          r_empty <= (w_minx > w_maxx) || (w_miny > w_maxy);
          r_state <= S_INIT;
        end
        S_INIT: if (w_skip) begin
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end else begin
          for (int i = 0; i < 3; i++) begin
            r_e[i]     <= w_e0[i];
            r_row_e[i] <= w_e0[i];
            r_stx[i]   <= w_stx[i];
            r_sty[i]   <= w_sty[i];
          end
          r_x        <= r_minx;
          r_y        <= r_miny;
          r_row_addr <= r_base + ADDR_W'($unsigned(r_miny)) * ADDR_W'(SCREEN_W);
          r_state    <= S_SCAN;
        end
        S_SCAN: if (w_o_free) begin
          // A new hit pushes the pending fragment out; the newest hit stays back in case it is the last.
          if (w_cov) begin
            r_p_vld  <= 1'b1;
            r_p_addr <= w_pix_addr;
            if (r_p_vld) begin
              r_o_vld   <= 1'b1;
              r_o_addr  <= r_p_addr;
              r_o_color <= r_color;
              r_o_last  <= 1'b0;
            end
          end
          if (w_last_px) begin
            r_state <= S_DRAIN;
          end else if (w_row_end) begin
            r_x        <= r_minx;
            r_y        <= r_y + crd_t'(1);
            r_row_addr <= r_row_addr + ADDR_W'(SCREEN_W);
            for (int i = 0; i < 3; i++) begin
              r_row_e[i] <= r_row_e[i] + r_sty[i];
              r_e[i]     <= r_row_e[i] + r_sty[i];
            end
          end else begin
            r_x <= r_x + crd_t'(1);
            for (int i = 0; i < 3; i++) r_e[i] <= r_e[i] + r_stx[i];
          end
        end
        S_DRAIN: if (r_p_vld) begin
          if (w_o_free) begin
            r_o_vld   <= 1'b1;
            r_o_addr  <= r_p_addr;
            r_o_color <= r_color;
            r_o_last  <= 1'b1;
            r_p_vld   <= 1'b0;
          end
        end else if (!r_o_vld) begin
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done     <= 1'b0;
          r_in_ready <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_o_vld;
  assign o_out_addr  = r_o_addr;
  assign o_out_color = r_o_color;
  assign o_out_last  = r_o_last;
  assign o_tri_done  = r_done;
endmodule

// File: tb/tb_tri_scan_rasterizer.sv
// Bench for tri_scan_rasterizer: table of triangles with a brute-force coverage model feeding a
// fragment scoreboard, plus stall and mid-scan reset sequences.
module tb_tri_scan_rasterizer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic signed [11:0] x1 = '0, y1 = '0, x2 = '0, y2 = '0, x3 = '0, y3 = '0;
  logic [23:0] color = '0;
  logic [25:0] base = '0;

  logic o0_in_ready, o0_valid, o0_last, o0_done;
  logic [25:0] o0_addr;
  logic [23:0] o0_color;
  logic o1_in_ready, o1_valid, o1_last, o1_done;
  logic [25:0] o1_addr;
  logic [23:0] o1_color;

  tri_scan_rasterizer #(.CULL_BACK(1'b0)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(o0_in_ready),
    .i_x1(x1), .i_y1(y1), .i_x2(x2), .i_y2(y2), .i_x3(x3), .i_y3(y3),
    .i_color1(color), .i_fb_base(base), .o_out_valid(o0_valid), .i_out_ready(out_ready),
    .o_out_addr(o0_addr), .o_out_color(o0_color), .o_out_last(o0_last), .o_tri_done(o0_done));

  tri_scan_rasterizer #(.CULL_BACK(1'b1)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(o1_in_ready),
    .i_x1(x1), .i_y1(y1), .i_x2(x2), .i_y2(y2), .i_x3(x3), .i_y3(y3),
    .i_color1(color), .i_fb_base(base), .o_out_valid(o1_valid), .i_out_ready(out_ready),
    .o_out_addr(o1_addr), .o_out_color(o1_color), .o_out_last(o1_last), .o_tri_done(o1_done));

  always #5 clk = ~clk;

  typedef struct {
    logic [25:0] addr;
    logic [23:0] color;
    logic        last;
  } frag_t;

  typedef struct {
    int x1, y1, x2, y2, x3, y3;
    int base, col;
    int n0, n1, first;
  } vec_t;

  frag_t exp_q[$];
  frag_t e;
  logic [25:0] obs_q[$];
  vec_t tbl [8];
  logic [25:0] t1_exp [10];
  int n_pass = 0, n_chk = 0, cyc = 0;
  int n0 = 0, n1 = 0, d0 = 0, d1 = 0;
  int acc_cyc = 0, first_cyc = 0, done_cyc = 0;
  logic [25:0] first_addr = '0;
  logic prev_stall = 1'b0;

  task automatic check(input string name, input longint act, input longint req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        check("hold_valid", o0_valid, 1);
        check("busy_in_ready", o0_in_ready, 0);
        if (exp_q.size() > 0) check("hold_addr", o0_addr, exp_q[0].addr);
      end
      if (o0_valid && out_ready) begin
        if (n0 == 0) begin
          first_addr = o0_addr;
          first_cyc  = cyc;
        end
        n0++;
        obs_q.push_back(o0_addr);
        if (exp_q.size() == 0) check("unexpected_frag", o0_addr, 0);
        else begin
          e = exp_q.pop_front();
          check("frag_addr", o0_addr, e.addr);
          check("frag_color", o0_color, e.color);
          check("frag_last", o0_last, e.last);
        end
      end
      prev_stall = o0_valid && !out_ready;
      if (o1_valid && out_ready) n1++;
      if (o0_done) begin
        d0++;
        done_cyc = cyc;
      end
      if (o1_done) d1++;
    end else prev_stall = 1'b0;
  end

  // Direct edge-function evaluation over every pixel of the clipped box.
  task automatic model(input vec_t v);
    int area, lx, hx, ly, hy, a, b, c, sz0;
    frag_t f;
    sz0  = exp_q.size();
    area = (v.x2-v.x1)*(v.y3-v.y1) - (v.y2-v.y1)*(v.x3-v.x1);
    if (area == 0) return;
    lx = v.x1; if (v.x2 < lx) lx = v.x2; if (v.x3 < lx) lx = v.x3; if (lx < 0) lx = 0;
    ly = v.y1; if (v.y2 < ly) ly = v.y2; if (v.y3 < ly) ly = v.y3; if (ly < 0) ly = 0;
    hx = v.x1; if (v.x2 > hx) hx = v.x2; if (v.x3 > hx) hx = v.x3; if (hx > 639) hx = 639;
    hy = v.y1; if (v.y2 > hy) hy = v.y2; if (v.y3 > hy) hy = v.y3; if (hy > 479) hy = 479;
    for (int y = ly; y <= hy; y++) begin
      for (int x = lx; x <= hx; x++) begin
        a = (v.x2-v.x1)*(y-v.y1) - (v.y2-v.y1)*(x-v.x1);
        b = (v.x3-v.x2)*(y-v.y2) - (v.y3-v.y2)*(x-v.x2);
        c = (v.x1-v.x3)*(y-v.y3) - (v.y1-v.y3)*(x-v.x3);
        if (area < 0) begin a = -a; b = -b; c = -c; end
        if (a >= 0 && b >= 0 && c >= 0) begin
          f.addr  = 26'(v.base + y*640 + x);
          f.color = 24'(v.col);
          f.last  = 1'b0;
          exp_q.push_back(f);
        end
      end
    end
    if (exp_q.size() > sz0) exp_q[exp_q.size()-1].last = 1'b1;
  endtask

  task automatic start_tri(input vec_t v);
    int t;
    t = 0;
    while (!(o0_in_ready && o1_in_ready) && t < 2000) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 2000) check("ready_timeout", t, 0);
    x1 = 12'(v.x1); y1 = 12'(v.y1); x2 = 12'(v.x2);
    y2 = 12'(v.y2); x3 = 12'(v.x3); y3 = 12'(v.y3);
    color = 24'(v.col);
    base  = 26'(v.base);
    n0 = 0; n1 = 0; d0 = 0; d1 = 0;
    obs_q.delete();
    model(v);
    acc_cyc  = cyc + 1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!o0_done && t < 5000) begin
      @(negedge clk); t++;
    end
    check("done_seen", o0_done, 1);
    check("in_ready_during_done", o0_in_ready, 0);
    @(negedge clk);
    check("in_ready_after_done", o0_in_ready, 1);
    check("done_one_cycle", o0_done, 0);
    @(negedge clk);
  endtask

  task automatic post_checks(input int i);
    vec_t v;
    v = tbl[i];
    check("n_frag", n0, v.n0);
    check("n_frag_cull", n1, v.n1);
    check("done_pulses", d0, 1);
    check("done_pulses_cull", d1, 1);
    check("queue_empty", exp_q.size(), 0);
    if (v.n0 > 0) check("first_addr", first_addr, 26'(v.first));
    if (i == 0) begin
      check("first_latency", first_cyc - acc_cyc, 4);
      check("t1_count", obs_q.size(), 10);
      for (int k = 0; k < 10 && k < obs_q.size(); k++) check("t1_order", obs_q[k], t1_exp[k]);
    end
    if (i == 2) check("degen_done_latency", (done_cyc - acc_cyc) <= 4, 1);
  endtask

  initial begin
    int t;
    tbl[0] = '{0, 0, 3, 0, 0, 3, 'h1000, 'hFF0000, 10, 10, 'h1000};
    tbl[1] = '{0, 0, 0, 3, 3, 0, 'h1000, 'h00FF00, 10, 0, 'h1000};
    tbl[2] = '{0, 0, 2, 2, 4, 4, 'h2000, 'h0000FF, 0, 0, 0};
    tbl[3] = '{630, 0, 650, 0, 630, 20, 'h4000, 'h123456, 165, 165, 'h4000 + 630};
    tbl[4] = '{700, 0, 710, 0, 700, 5, 'h4000, 'h111111, 0, 0, 0};
    tbl[5] = '{5, 5, 6, 5, 5, 6, 'h3FFFFFF, 'hABCDEF, 3, 3, 'hC84};
    tbl[6] = '{-3, -3, 3, -3, -3, 3, 'h8000, 'hC0FFEE, 1, 1, 'h8000};
    tbl[7] = '{2, 2, 2, 2, 2, 2, 'h9000, 'h777777, 0, 0, 0};
    t1_exp = '{26'h1000, 26'h1001, 26'h1002, 26'h1003, 26'h1280,
               26'h1281, 26'h1282, 26'h1500, 26'h1501, 26'h1780};

    #12;
    check("rst_in_ready", o0_in_ready, 1);
    check("rst_out_valid", o0_valid, 0);
    check("rst_out_last", o0_last, 0);
    check("rst_tri_done", o0_done, 0);
    check("rst_out_addr", o0_addr, 0);
    check("rst_out_color", o0_color, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      start_tri(tbl[i]);
      wait_done();
      post_checks(i);
    end

    // Downstream stall mid-stream.
    start_tri(tbl[0]);
    t = 0;
    while (n0 < 3 && t < 200) begin
      @(posedge clk); #1; t++;
    end
    out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_done();
    post_checks(0);

    // Reset during scan aborts the triangle.
    start_tri(tbl[0]);
    t = 0;
    while (n0 < 3 && t < 200) begin
      @(posedge clk); #1; t++;
    end
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", o0_valid, 0);
    check("abort_in_ready", o0_in_ready, 1);
    check("abort_tri_done", o0_done, 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    start_tri(tbl[0]);
    wait_done();
    post_checks(0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
